// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = x - y - b_in, one bit per clock, LSB first.
// One full-subtractor cell, operand shift registers and a registered borrow.
module serial_subtractor #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         b_out
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  xs_q, xs_d;
  logic [W-1:0]  ys_q, ys_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          bout_q, bout_d;

  logic xi, yi, diff_bit, borrow_nxt;

  // Single full-subtractor cell fed from the operand shift registers.
  assign xi         = xs_q[0];
  assign yi         = ys_q[0];
  assign diff_bit   = xi ^ yi ^ br_q;
  assign borrow_nxt = (~xi & yi) | (~(xi ^ yi) & br_q);

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          xs_d    = x;
          ys_d    = y;
          br_d    = b_in;
          cnt_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d = {diff_bit, res_q[W-1:1]};
        xs_d  = xs_q >> 1;
        ys_d  = ys_q >> 1;
        br_d  = borrow_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          bout_d  = borrow_nxt;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  // Outputs decode straight from registers; no input-to-output path.
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign d     = res_q;
  assign b_out = bout_q;

endmodule
